// File: rtl/fetch_decode_unit.sv
// Front end of the 8-bit CPU: instruction register, program counter and memory
// address mux, loaded from the data bus under controller fetch strobes.
module fetch_decode_unit #(
    parameter int          DATA_W   = 8,
    parameter logic [11:0] PC_RESET = 12'h000,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [4:0]        ctrl_state,
    input  logic [1:0]        fetch,
    input  logic              PC_en,
    input  logic              pc_in,
    input  logic              ad_sel,
    output logic [3:0]        ins,
    output logic [11:0]       ir_addr,
    output logic [11:0]       addr,
    output logic [11:0]       pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [4:0]       S0      = 5'd0;
    localparam logic [4:0]       S2      = 5'd2;
    localparam logic [3:0]       OP_HLT  = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0] ir;
    logic        opcode_cap;
    logic        operand_cap;

    // Strobes are single-cycle qualifiers sampled at the rising edge: an opcode
    // byte is taken only in S0 with fetch=01; an operand byte needs fetch=10 with PC_en.
    assign opcode_cap  = (ctrl_state == S0) && (fetch == 2'b01);
    assign operand_cap = (fetch == 2'b10) && PC_en;

    assign ins     = ir[15:12];
    assign ir_addr = ir[11:0];
    assign addr    = ad_sel ? ir_addr : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir        <= 16'h0000;
            pc        <= PC_RESET;
            halted    <= 1'b0;
            fetch_cnt <= '0;
        end else if (!halted) begin
            if (opcode_cap) begin
                ir <= {data_in, 8'h00};
                if (fetch_cnt != CNT_MAX)
                    fetch_cnt <= fetch_cnt + CNT_W'(1);
            end else if (operand_cap) begin
                ir[7:0] <= data_in;
            end

            // Jump target uses the pre-edge IR page even if an opcode lands this edge.
            if (PC_en && pc_in)
                pc <= {ir[11:8], data_in};
            else if (PC_en)
                pc <= pc + 12'd1;

            if ((ctrl_state == S2) && (ir[15:12] == OP_HLT))
                halted <= 1'b1;
        end
    end

endmodule
